// File: rtl/rem_pkg.sv
// Shared types and sizes for the sequential remainder engine.
// The REM_QUOT_EN build option adds a quotient write-back state (WRITE_Q).
`timescale 1ns/1ps
package rem_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [AW-1:0]    addr_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_X    = 3'd1,
        RD_Y    = 3'd2,
        SUB     = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5,
        WRITE_Q = 3'd6
    } state_e;

    // Register-file write request.
    typedef struct packed {
        logic  we;
        addr_t addr;
        word_t data;
    } wr_req_t;

    // Entry following a, wrapping modulo DEPTH.
    function automatic addr_t addr_inc(input addr_t a);
        return a + AW'(1);
    endfunction

endpackage

// File: rtl/regfile_8x16.sv
// 8x16 register file: async-reset storage, one synchronous write port,
// one operand read port for the engine and one host read port.
`timescale 1ns/1ps
module regfile_8x16
    import rem_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  wr_req_t wr_i,
    input  addr_t   op_addr_i,
    output word_t   op_data_o,
    input  addr_t   host_addr_i,
    output word_t   host_data_o
);

    word_t mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_i.we) begin
            mem_q[wr_i.addr] <= wr_i.data;
        end
    end

    assign op_data_o   = mem_q[op_addr_i];
    assign host_data_o = mem_q[host_addr_i];

endmodule

// File: rtl/rem_seq_ctrl.sv
// Sequential remainder engine: one conditional subtraction per clock on
// register-file operands. Define REM_QUOT_EN to also write the quotient.
`timescale 1ns/1ps
module rem_seq_ctrl
    import rem_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             start,
    input  logic [AW-1:0]    addr_x,
    input  logic [AW-1:0]    addr_y,
    input  logic [AW-1:0]    addr_r,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    state_e  state_q, state_d;
    word_t   temp_q, temp_d;
    word_t   y_q, y_d;
    addr_t   ax_q, ax_d;
    addr_t   ay_q, ay_d;
    addr_t   ar_q, ar_d;
    logic    dz_q, dz_d;
    logic    busy_q, done_q;
`ifdef REM_QUOT_EN
    word_t   quot_q, quot_d;
`endif

    wr_req_t wr_c;
    addr_t   op_addr_c;
    word_t   op_data_c;

    regfile_8x16 u_regfile (
        .clk         (CLK),
        .rst_n       (RST_N),
        .wr_i        (wr_c),
        .op_addr_i   (op_addr_c),
        .op_data_o   (op_data_c),
        .host_addr_i (rd_addr),
        .host_data_o (rd_data)
    );

    // Next-state, datapath and register-file write arbitration.
    always_comb begin
        state_d   = state_q;
        temp_d    = temp_q;
        y_d       = y_q;
        ax_d      = ax_q;
        ay_d      = ay_q;
        ar_d      = ar_q;
        dz_d      = dz_q;
`ifdef REM_QUOT_EN
        quot_d    = quot_q;
`endif
        wr_c      = '0;
        op_addr_c = ax_q;

        case (state_q)
            IDLE: begin
                // Host writes only land while idle.
                if (wr_en) begin
                    wr_c.we   = 1'b1;
                    wr_c.addr = wr_addr;
                    wr_c.data = wr_data;
                end
                if (start) begin
                    ax_d    = addr_x;
                    ay_d    = addr_y;
                    ar_d    = addr_r;
                    dz_d    = 1'b0;
`ifdef REM_QUOT_EN
                    quot_d  = '0;
`endif
                    state_d = RD_X;
                end
            end
            RD_X: begin
                op_addr_c = ax_q;
                temp_d    = op_data_c;
                state_d   = RD_Y;
            end
            RD_Y: begin
                op_addr_c = ay_q;
                y_d       = op_data_c;
                state_d   = SUB;
            end
            SUB: begin
                if (y_q == '0) begin
                    dz_d    = 1'b1;
                    state_d = WRITE;
                end else if (temp_q >= y_q) begin
                    temp_d  = temp_q - y_q;
`ifdef REM_QUOT_EN
                    quot_d  = quot_q + WIDTH'(1);
`endif
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                wr_c.we   = 1'b1;
                wr_c.addr = ar_q;
                wr_c.data = temp_q;
`ifdef REM_QUOT_EN
                state_d   = WRITE_Q;
`else
                state_d   = DONE;
`endif
            end
`ifdef REM_QUOT_EN
            WRITE_Q: begin
                wr_c.we   = 1'b1;
                wr_c.addr = addr_inc(ar_q);
                wr_c.data = dz_q ? '1 : quot_q;
                state_d   = DONE;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; busy/done follow the next state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            temp_q  <= '0;
            y_q     <= '0;
            ax_q    <= '0;
            ay_q    <= '0;
            ar_q    <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef REM_QUOT_EN
            quot_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            temp_q  <= temp_d;
            y_q     <= y_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            ar_q    <= ar_d;
            dz_q    <= dz_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
`ifdef REM_QUOT_EN
            quot_q  <= quot_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_rem_seq_ctrl.sv
// Scoreboard bench for rem_seq_ctrl: stimulus pushes expected register-file
// images and done timing, a monitor pops and compares on each done or reset.
`timescale 1ns/1ps
module tb_rem_seq_ctrl;

    localparam int unsigned W = 16;
    localparam int unsigned D = 8;
`ifdef REM_QUOT_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic         CLK;
    logic         RST_N;
    logic         wr_en;
    logic [2:0]   wr_addr;
    logic [W-1:0] wr_data;
    logic [2:0]   rd_addr;
    logic [W-1:0] rd_data;
    logic         start;
    logic [2:0]   addr_x;
    logic [2:0]   addr_y;
    logic [2:0]   addr_r;
    logic         busy;
    logic         done;
    logic         div_zero;

    typedef struct packed {
        logic                 rst_chk;
        int                   exp_cyc;
        logic                 dz;
        logic [D-1:0][W-1:0]  mem;
    } exp_t;

    exp_t                 sb_q[$];
    logic [D-1:0][W-1:0]  mem_m;
    int                   cyc = 0;
    int                   checks = 0;
    int                   errors = 0;
    int                   to_cnt = 0;
    bit                   end_req = 1'b0;

    rem_seq_ctrl dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .start    (start),
        .addr_x   (addr_x),
        .addr_y   (addr_y),
        .addr_r   (addr_r),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial begin
        CLK = 1'b0;
        forever #20 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sweep(input logic [D-1:0][W-1:0] m);
        for (int i = 0; i < int'(D); i++) begin
            rd_addr = 3'(i);
            #1;
            chk($sformatf("mem[%0d]", i), int'(rd_data), int'(m[i]));
        end
    endtask

    initial begin : monitor
        exp_t e;
        int   to_seen;
        to_seen = 0;
        rd_addr = '0;
        forever begin
            @(negedge CLK);
            if (to_cnt != to_seen) begin
                chk("done_timeout", to_cnt, to_seen);
                to_seen = to_cnt;
            end
            if (done === 1'b1) begin
                if (sb_q.size() == 0 || sb_q[0].rst_chk) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 with no operation pending (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_cycle", cyc, e.exp_cyc);
                    chk("div_zero", int'(div_zero), int'(e.dz));
                    chk("busy_at_done", int'(busy), 1);
                    sweep(e.mem);
                end
            end else if (sb_q.size() > 0 && sb_q[0].rst_chk) begin
                e = sb_q.pop_front();
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_div_zero", int'(div_zero), 0);
                sweep(e.mem);
            end
            if (end_req) begin
                chk("pending_ops", sb_q.size(), 0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    // ---------------- stimulus + reference model ----------------
    task automatic push_rst();
        exp_t e;
        e = '0;
        e.rst_chk = 1'b1;
        e.mem = mem_m;
        sb_q.push_back(e);
    endtask

    task automatic host_write(input logic [2:0] a, input logic [W-1:0] d);
        @(negedge CLK);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        mem_m[a] = d;
        @(negedge CLK);
        wr_en   = 1'b0;
    endtask

    // Issue one operation; the model follows the remainder/quotient definition.
    task automatic run_op(input logic [2:0] ax, input logic [2:0] ay, input logic [2:0] ar,
                          input bit junk, input bit same_wr, input logic [W-1:0] same_val);
        exp_t         e;
        logic [W-1:0] x, y, r, q;
        logic [2:0]   aq;
        logic         dz;
        int           k, n;
        @(negedge CLK);
        if (same_wr) begin
            wr_en    = 1'b1;
            wr_addr  = ax;
            wr_data  = same_val;
            mem_m[ax] = same_val;
        end
        x = mem_m[ax];
        y = mem_m[ay];
        if (y == '0) begin
            r = x; q = '1; k = 0; dz = 1'b1;
        end else begin
            r = x % y; q = x / y; k = int'(q); dz = 1'b0;
        end
        mem_m[ar] = r;
        aq = ar + 3'd1;
        if (EXTRA == 1) mem_m[aq] = q;
        start  = 1'b1;
        addr_x = ax;
        addr_y = ay;
        addr_r = ar;
        e = '0;
        e.exp_cyc = cyc + k + 5 + EXTRA;
        e.dz = dz;
        e.mem = mem_m;
        sb_q.push_back(e);
        @(negedge CLK);
        start = 1'b0;
        wr_en = 1'b0;
        if (junk) begin
            @(negedge CLK);
            wr_en   = 1'b1;
            wr_addr = 3'd2;
            wr_data = 16'hBEEF;
            start   = 1'b1;
            addr_x  = ~ax;
            addr_y  = ~ay;
            addr_r  = 3'd2;
            @(negedge CLK);
            wr_en = 1'b0;
            start = 1'b0;
        end
        n = 0;
        while (done !== 1'b1 && n < k + 40) begin
            @(negedge CLK);
            n++;
        end
        if (done !== 1'b1) to_cnt++;
        @(negedge CLK);
    endtask

    initial begin : stim
        int          lim;
        logic [2:0]  ax, ay, ar;
        logic [W-1:0] xv, yv, sv;
        RST_N = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; addr_x = '0; addr_y = '0; addr_r = '0;
        mem_m = '0;
        push_rst();
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;

        // Basic remainder, zero-subtraction case, divide-by-zero.
        host_write(3'd0, 16'd100); host_write(3'd1, 16'd7);
        run_op(3'd0, 3'd1, 3'd2, 1'b0, 1'b0, '0);
        host_write(3'd0, 16'd5); host_write(3'd1, 16'd9);
        run_op(3'd0, 3'd1, 3'd2, 1'b0, 1'b0, '0);
        host_write(3'd4, 16'd1234); host_write(3'd5, 16'd0);
        run_op(3'd4, 3'd5, 3'd6, 1'b0, 1'b0, '0);

        // Reset in the middle of a long operation.
        host_write(3'd0, 16'hFFFF); host_write(3'd1, 16'd1);
        @(negedge CLK);
        start = 1'b1; addr_x = 3'd0; addr_y = 3'd1; addr_r = 3'd2;
        @(negedge CLK);
        start = 1'b0;
        repeat (8) @(negedge CLK);
        RST_N = 1'b0;
        mem_m = '0;
        #1;
        push_rst();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        // Host write and start while busy are dropped.
        host_write(3'd0, 16'd100); host_write(3'd1, 16'd7);
        run_op(3'd0, 3'd1, 3'd2, 1'b1, 1'b0, '0);
        // Result overwrites its own dividend entry.
        host_write(3'd3, 16'd50); host_write(3'd4, 16'd8);
        run_op(3'd3, 3'd4, 3'd3, 1'b0, 1'b0, '0);
        // Same-cycle write and start: the operation sees the new value.
        run_op(3'd0, 3'd1, 3'd5, 1'b0, 1'b1, 16'd77);
        // Same entry as dividend and divisor.
        host_write(3'd6, 16'd999);
        run_op(3'd6, 3'd6, 3'd7, 1'b0, 1'b0, '0);

        for (int it = 0; it < 30; it++) begin
            ax = 3'($urandom_range(0, 7));
            ay = 3'($urandom_range(0, 7));
            ar = 3'($urandom_range(0, 7));
            yv = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            lim = (yv == 0) ? 65535 : int'(yv) * 200;
            if (lim > 65535) lim = 65535;
            xv = 16'($urandom_range(0, lim));
            sv = 16'($urandom_range(0, lim));
            host_write(ax, xv);
            host_write(ay, yv);
            run_op(ax, ay, ar, bit'($urandom_range(0, 3) == 0),
                   bit'($urandom_range(0, 3) == 0), sv);
        end

        repeat (2) @(negedge CLK);
        end_req = 1'b1;
    end

endmodule
